// File: rtl/traffic_light_monitor.sv
// Receiving-end safety monitor for a two-direction traffic-light lamp interface.
// Optional ERR_COUNT fault-event counter is built when MONITOR_ERRCNT_EN is defined.
module traffic_light_monitor #(
    parameter int MIN_YLW = 3,
    parameter int MAX_GRN = 200,
    parameter int CNT_W   = 8
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    output logic       FAULT,
    output logic [2:0] FAULT_CODE,
    output logic [1:0] FAULT_DIR,
    output logic [1:0] PHASE1,
    output logic [1:0] PHASE2,
    output logic       ALLRED
`ifdef MONITOR_ERRCNT_EN
    ,
    output logic [7:0] ERR_COUNT
`endif
);

    typedef enum logic [1:0] {
        PH_UNK = 2'd0,
        PH_RED = 2'd1,
        PH_GRN = 2'd2,
        PH_YLW = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] GRN_LIMIT = CNT_W'(MAX_GRN + 1);
    localparam logic [CNT_W-1:0] YLW_MIN   = CNT_W'(MIN_YLW);

    // Sample layout: [2:0] = {RED1,YLW1,GRN1}, [5:3] = {RED2,YLW2,GRN2}
    logic [5:0]       samp_reg;
    logic             samp_vld_reg;
    phase_t           phase_reg [2];
    logic [CNT_W-1:0] dwell_reg [2];
    logic             fault_reg;
    logic [2:0]       code_reg;
    logic [1:0]       dir_reg;
    logic             allred_reg;

    logic [1:0]       legal;
    logic [1:0]       held;
    logic [1:0]       enc_err;
    logic [1:0]       trans_err;
    logic [1:0]       short_err;
    logic [1:0]       tmo_err;
    phase_t           samp_ph    [2];
    phase_t           phase_next [2];
    logic [CNT_W-1:0] dwell_next [2];

    logic             conflict;
    logic [2:0]       evt_code;
    logic [1:0]       evt_dir;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            logic [2:0] lamps;
            assign lamps       = samp_reg[gi*3 +: 3];
            assign legal[gi]   = $onehot(lamps);
            assign samp_ph[gi] = lamps[0] ? PH_GRN : (lamps[1] ? PH_YLW : PH_RED);
            assign held[gi]    = (samp_ph[gi] == phase_reg[gi]);

            // Illegal encodings freeze phase and dwell for that direction
            assign phase_next[gi] = (samp_vld_reg && legal[gi]) ? samp_ph[gi] : phase_reg[gi];
            assign dwell_next[gi] = !(samp_vld_reg && legal[gi]) ? dwell_reg[gi] :
                                    !held[gi]                    ? CNT_W'(1) :
                                    (dwell_reg[gi] == DWELL_MAX) ? DWELL_MAX :
                                                                   dwell_reg[gi] + CNT_W'(1);

            assign enc_err[gi]   = samp_vld_reg && !legal[gi];
            assign trans_err[gi] = samp_vld_reg && legal[gi] && !held[gi] && (phase_reg[gi] != PH_UNK) &&
                                   !((phase_reg[gi] == PH_RED && samp_ph[gi] == PH_GRN) ||
                                     (phase_reg[gi] == PH_GRN && samp_ph[gi] == PH_YLW) ||
                                     (phase_reg[gi] == PH_YLW && samp_ph[gi] == PH_RED));
            assign short_err[gi] = samp_vld_reg && legal[gi] && (phase_reg[gi] == PH_YLW) &&
                                   (samp_ph[gi] == PH_RED) && (dwell_reg[gi] < YLW_MIN);
            // Fires only on the cycle the green dwell first reaches the limit
            assign tmo_err[gi]   = samp_vld_reg && legal[gi] && (samp_ph[gi] == PH_GRN) &&
                                   (dwell_next[gi] == GRN_LIMIT) &&
                                   !(held[gi] && dwell_reg[gi] == GRN_LIMIT);
        end
    endgenerate

    assign conflict = samp_vld_reg && (&legal) && (samp_ph[0] != PH_RED) && (samp_ph[1] != PH_RED);

    always_comb begin
        evt_code = 3'd0;
        evt_dir  = 2'b00;
        if (conflict) begin
            evt_code = 3'd3;
            evt_dir  = 2'b11;
        end else if (|enc_err) begin
            evt_code = 3'd1;
            evt_dir  = enc_err;
        end else if (|trans_err) begin
            evt_code = 3'd2;
            evt_dir  = trans_err;
        end else if (|short_err) begin
            evt_code = 3'd4;
            evt_dir  = short_err;
        end else if (|tmo_err) begin
            evt_code = 3'd5;
            evt_dir  = tmo_err;
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            samp_reg     <= '0;
            samp_vld_reg <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                phase_reg[d] <= PH_UNK;
                dwell_reg[d] <= '0;
            end
            fault_reg  <= 1'b0;
            code_reg   <= 3'd0;
            dir_reg    <= 2'b00;
            allred_reg <= 1'b0;
        end else begin
            samp_reg     <= {RED2, YLW2, GRN2, RED1, YLW1, GRN1};
            samp_vld_reg <= 1'b1;
            for (int d = 0; d < 2; d++) begin
                phase_reg[d] <= phase_next[d];
                dwell_reg[d] <= dwell_next[d];
            end
            allred_reg <= (phase_next[0] == PH_RED) && (phase_next[1] == PH_RED);
            if ((evt_code != 3'd0) && !fault_reg) begin
                fault_reg <= 1'b1;
                code_reg  <= evt_code;
                dir_reg   <= evt_dir;
            end
        end
    end

`ifdef MONITOR_ERRCNT_EN
    logic [7:0] errcnt_reg;

    always_ff @(posedge CK) begin
        if (CLR) begin
            errcnt_reg <= 8'd0;
        end else if ((evt_code != 3'd0) && (errcnt_reg != 8'hFF)) begin
            errcnt_reg <= errcnt_reg + 8'd1;
        end
    end

    assign ERR_COUNT = errcnt_reg;
`endif

    assign FAULT      = fault_reg;
    assign FAULT_CODE = code_reg;
    assign FAULT_DIR  = dir_reg;
    assign PHASE1     = phase_reg[0];
    assign PHASE2     = phase_reg[1];
    assign ALLRED     = allred_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table, directed corner sequences,
// and randomized lamp traffic against a phase/dwell reference model.
module tb_traffic_light_monitor;

    localparam int MIN_YLW = 3;
    localparam int MAX_GRN = 200;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] YR = 3'b110;

    logic       CK = 1'b0;
    logic       CLR = 1'b1;
    logic       GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b0;
    logic       GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b0;
    logic       FAULT;
    logic [2:0] FAULT_CODE;
    logic [1:0] FAULT_DIR;
    logic [1:0] PHASE1;
    logic [1:0] PHASE2;
    logic       ALLRED;
`ifdef MONITOR_ERRCNT_EN
    logic [7:0] ERR_COUNT;
`endif

    always #5 CK = ~CK;

    traffic_light_monitor #(
        .MIN_YLW(MIN_YLW),
        .MAX_GRN(MAX_GRN),
        .CNT_W  (8)
    ) dut (
        .CK        (CK),
        .CLR       (CLR),
        .GRN1      (GRN1),
        .YLW1      (YLW1),
        .RED1      (RED1),
        .GRN2      (GRN2),
        .YLW2      (YLW2),
        .RED2      (RED2),
        .FAULT     (FAULT),
        .FAULT_CODE(FAULT_CODE),
        .FAULT_DIR (FAULT_DIR),
        .PHASE1    (PHASE1),
        .PHASE2    (PHASE2),
        .ALLRED    (ALLRED)
`ifdef MONITOR_ERRCNT_EN
        ,
        .ERR_COUNT (ERR_COUNT)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: phases 0 UNK, 1 RED, 2 GRN, 3 YLW; legal successor of p is p%3+1
    bit         m_vld;
    logic [5:0] m_samp;
    int         m_ph [2];
    int         m_dw [2];
    bit         m_f;
    int         m_code, m_dir, m_err;

    task automatic model_step(input logic c, input logic [5:0] l);
        int  sp [2];
        bit  ok [2];
        int  nd [2];
        int  mask [6];
        int  prio [5];
        int  win;
        logic [2:0] b;
        if (c) begin
            m_vld = 0; m_samp = '0; m_f = 0; m_code = 0; m_dir = 0; m_err = 0;
            m_ph[0] = 0; m_ph[1] = 0; m_dw[0] = 0; m_dw[1] = 0;
            return;
        end
        if (m_vld) begin
            mask = '{default: 0};
            prio = '{3, 1, 2, 4, 5};
            for (int d = 0; d < 2; d++) begin
                b      = m_samp[d*3 +: 3];
                ok[d]  = ($countones(b) == 1);
                sp[d]  = b[0] ? 2 : (b[1] ? 3 : 1);
                nd[d]  = m_dw[d];
                if (!ok[d]) begin
                    mask[1] |= (1 << d);
                end else begin
                    if (sp[d] == m_ph[d]) begin
                        nd[d] = (m_dw[d] < 255) ? m_dw[d] + 1 : 255;
                    end else begin
                        nd[d] = 1;
                        if (m_ph[d] != 0 && sp[d] != (m_ph[d] % 3) + 1) mask[2] |= (1 << d);
                        if (m_ph[d] == 3 && sp[d] == 1 && m_dw[d] < MIN_YLW) mask[4] |= (1 << d);
                    end
                    if (sp[d] == 2 && nd[d] == MAX_GRN + 1 && !(sp[d] == m_ph[d] && m_dw[d] == nd[d]))
                        mask[5] |= (1 << d);
                end
            end
            if (ok[0] && ok[1] && sp[0] != 1 && sp[1] != 1) mask[3] = 3;
            win = 0;
            for (int i = 0; i < 5; i++)
                if (win == 0 && mask[prio[i]] != 0) win = prio[i];
            if (win != 0) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
                if (!m_f) begin
                    m_f = 1; m_code = win; m_dir = mask[win];
                end
            end
            for (int d = 0; d < 2; d++)
                if (ok[d]) begin
                    m_ph[d] = sp[d];
                    m_dw[d] = nd[d];
                end
        end
        m_samp = l;
        m_vld  = 1;
    endtask

    task automatic cyc(input logic c, input logic [2:0] d1, input logic [2:0] d2);
        @(negedge CK);
        CLR = c;
        {RED1, YLW1, GRN1} = d1;
        {RED2, YLW2, GRN2} = d2;
        @(posedge CK);
        #1;
        model_step(c, {d2, d1});
    endtask

    task automatic run(input int n, input logic [2:0] d1, input logic [2:0] d2);
        for (int i = 0; i < n; i++) cyc(1'b0, d1, d2);
    endtask

    task automatic check_out(input string tag, input int f, input int code, input int dir,
                             input int p1, input int p2, input int ar);
        chk({tag, ".fault"}, FAULT, f);
        chk({tag, ".code"}, FAULT_CODE, code);
        chk({tag, ".dir"}, FAULT_DIR, dir);
        chk({tag, ".phase1"}, PHASE1, p1);
        chk({tag, ".phase2"}, PHASE2, p2);
        chk({tag, ".allred"}, ALLRED, ar);
    endtask

    task automatic check_model(input int idx);
        string tag;
        tag = $sformatf("rnd%0d", idx);
        check_out(tag, m_f, m_code, m_dir, m_ph[0], m_ph[1], (m_ph[0] == 1 && m_ph[1] == 1));
`ifdef MONITOR_ERRCNT_EN
        chk({tag, ".errcnt"}, ERR_COUNT, m_err);
`endif
    endtask

    typedef struct {
        logic       clr;
        logic [2:0] d1;
        logic [2:0] d2;
        logic       f;
        logic [2:0] code;
        logic [1:0] dir;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       ar;
    } vec_t;

    vec_t tbl [15];
    int   cur [2] = '{1, 1};
    logic [2:0] rl [2];

    initial begin
        // Conflict then short yellow (code 3 holds); then RED->YLW jump (code 2)
        tbl[0]  = '{1'b1, R, R, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, R, R, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, R, R, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, R, R, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, G, G, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, G, G, 1'b1, 3'd3, 2'd3, 2'd2, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, Y, G, 1'b1, 3'd3, 2'd3, 2'd2, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, R, G, 1'b1, 3'd3, 2'd3, 2'd3, 2'd2, 1'b0};
        tbl[8]  = '{1'b0, R, G, 1'b1, 3'd3, 2'd3, 2'd1, 2'd2, 1'b0};
        tbl[9]  = '{1'b1, R, R, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, R, R, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, R, R, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 1'b1};
        tbl[12] = '{1'b0, Y, R, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 1'b1};
        tbl[13] = '{1'b0, R, R, 1'b1, 3'd2, 2'd1, 2'd3, 2'd1, 1'b0};
        tbl[14] = '{1'b0, R, R, 1'b1, 3'd2, 2'd1, 2'd1, 2'd1, 1'b1};

        // Legal full cycle on both directions
        cyc(1'b1, R, R);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        cyc(1'b1, R, R);
        run(10, R, R);
        check_out("legal.allred1", 0, 0, 0, 1, 1, 1);
        run(20, G, R);
        check_out("legal.grn1", 0, 0, 0, 2, 1, 0);
        run(3, Y, R);
        check_out("legal.ylw1", 0, 0, 0, 3, 1, 0);
        run(5, R, R);
        check_out("legal.allred2", 0, 0, 0, 1, 1, 1);
        run(20, R, G);
        check_out("legal.grn2", 0, 0, 0, 1, 2, 0);
        run(3, R, Y);
        check_out("legal.ylw2", 0, 0, 0, 1, 3, 0);
        run(5, R, R);
        check_out("legal.allred3", 0, 0, 0, 1, 1, 1);
        $display("legal sequence done: FAULT=%0d PHASE1=%0d PHASE2=%0d", FAULT, PHASE1, PHASE2);

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].clr, tbl[i].d1, tbl[i].d2);
            $display("vec %0d: clr=%0d d1=%b d2=%b -> F=%0d C=%0d D=%0d P1=%0d P2=%0d AR=%0d",
                     i, tbl[i].clr, tbl[i].d1, tbl[i].d2, FAULT, FAULT_CODE, FAULT_DIR,
                     PHASE1, PHASE2, ALLRED);
            check_out($sformatf("vec%0d", i), tbl[i].f, tbl[i].code, tbl[i].dir,
                      tbl[i].p1, tbl[i].p2, tbl[i].ar);
        end

        // Short yellow (2 cycles) on dir1, then the 3-cycle yellow that must pass
        cyc(1'b1, R, R);
        run(4, R, R);
        run(10, G, R);
        run(2, Y, R);
        cyc(1'b0, R, R);
        chk("short.before", FAULT, 0);
        cyc(1'b0, R, R);
        check_out("short.latched", 1, 4, 1, 1, 1, 1);
        cyc(1'b1, R, R);
        run(4, R, R);
        run(10, G, R);
        run(3, Y, R);
        run(3, R, R);
        check_out("ylw3.ok", 0, 0, 0, 1, 1, 1);
        $display("short-yellow sequences done: FAULT=%0d CODE=%0d", FAULT, FAULT_CODE);

        // Illegal encoding on dir2: phase holds, then CLR clears everything
        cyc(1'b1, R, R);
        run(4, R, R);
        cyc(1'b0, R, YR);
        chk("enc.before", FAULT, 0);
        cyc(1'b0, R, R);
        check_out("enc.latched", 1, 1, 2, 1, 1, 1);
        cyc(1'b1, R, R);
        check_out("enc.clr", 0, 0, 0, 0, 0, 0);
`ifdef MONITOR_ERRCNT_EN
        chk("enc.clr.errcnt", ERR_COUNT, 0);
`endif

        // CLR on the edge that would latch a conflict wins
        run(3, R, R);
        cyc(1'b0, G, G);
        cyc(1'b1, R, R);
        chk("clrovr.edge", FAULT, 0);
        run(2, R, R);
        check_out("clrovr.after", 0, 0, 0, 1, 1, 1);
        $display("encoding/CLR sequences done: FAULT=%0d", FAULT);

        // Green timeout: fault on the cycle dwell becomes MAX_GRN+1
        cyc(1'b1, R, R);
        run(3, R, R);
        run(MAX_GRN + 1, G, R);
        chk("tmo.before", FAULT, 0);
        cyc(1'b0, G, R);
        check_out("tmo.latched", 1, 5, 1, 2, 1, 0);
`ifdef MONITOR_ERRCNT_EN
        chk("tmo.errcnt1", ERR_COUNT, 1);
`endif
        run(3, Y, R);
        run(3, R, R);
`ifdef MONITOR_ERRCNT_EN
        chk("tmo.errcnt_hold", ERR_COUNT, 1);
`endif
        run(2, Y, R);
        check_out("tmo.jump", 1, 5, 1, 3, 1, 0);
`ifdef MONITOR_ERRCNT_EN
        chk("tmo.errcnt2", ERR_COUNT, 2);
`endif
        $display("green-timeout sequence done: CODE=%0d DIR=%0d", FAULT_CODE, FAULT_DIR);

        // Randomized lamp traffic against the reference model
        cyc(1'b1, R, R);
        for (int i = 0; i < 1500; i++) begin
            int   r;
            logic c;
            for (int d = 0; d < 2; d++) begin
                r = $urandom_range(0, 99);
                if (r < 10) cur[d] = (cur[d] % 3) + 1;
                else if (r < 13) cur[d] = $urandom_range(1, 3);
                rl[d] = (cur[d] == 1) ? R : ((cur[d] == 2) ? G : Y);
                if (r >= 97) rl[d] = 3'($urandom_range(0, 7));
            end
            c = ($urandom_range(0, 99) < 2);
            cyc(c, rl[0], rl[1]);
            check_model(i);
        end
        $display("random phase done: last FAULT=%0d CODE=%0d", FAULT, FAULT_CODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
